// File: rtl/mmu_pmpout_arb.sv
// Round-robin arbiter sharing one PMP-result output register between two check pipes,
// routing the held result to dcache, retire or the exception unit.
module mmu_pmpout_arb #(
  parameter int DATA_W = 51,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req0_valid,
  input  logic [DATA_W-1:0] i_req0_data,
  output logic              o_req0_ready,
  input  logic              i_req1_valid,
  input  logic [DATA_W-1:0] i_req1_data,
  output logic              o_req1_ready,
  output logic              o_dcache_valid,
  input  logic              i_dcache_ready,
  output logic [37:0]       o_dcache_data,
  output logic              o_retire_valid,
  input  logic              i_retire_ready,
  output logic [10:0]       o_retire_data,
  output logic              o_exp_valid,
  input  logic              i_exp_ready,
  output logic [4:0]        o_exp_data,
  output logic              o_owner,
  output logic [CNT_W-1:0]  o_fault_cnt0,
  output logic [CNT_W-1:0]  o_fault_cnt1
);

  typedef enum logic [1:0] {
    DEST_DCACHE = 2'd0,
    DEST_RETIRE = 2'd1,
    DEST_EXP    = 2'd2
  } dest_e;

  // Held output stage.
  logic              full;
  logic [DATA_W-1:0] pkt_q;
  logic              owner_q;
  dest_e             dest_q;
  logic              last_grant;
  logic [CNT_W-1:0]  cnt0_q;
  logic [CNT_W-1:0]  cnt1_q;

  logic              sel_ready;
  logic              drain;
  logic              can_accept;
  logic              grant0;
  logic              grant1;
  logic              accept;
  logic [DATA_W-1:0] win_data;
  logic              win_fault;
  dest_e             win_dest;

  // itype[0] carries no routing meaning; its copy in the held register is never read.
  logic              unused_itype0;
  assign unused_itype0 = win_data[34] ^ pkt_q[34];

  // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    sel_ready = 1'b0;
    unique case (dest_q)
      DEST_DCACHE: sel_ready = i_dcache_ready;
      DEST_RETIRE: sel_ready = i_retire_ready;
      DEST_EXP:    sel_ready = i_exp_ready;
      default:     sel_ready = 1'b0;
    endcase
  end

  // During reset the held packet is dropped silently, so no handshake may be offered.
  assign drain      = full & sel_ready & ~rst;
  assign can_accept = (~full | drain) & ~rst;

  // On a tie the requester that did not win last time goes next.
  assign grant0 = i_req0_valid & (~i_req1_valid | last_grant);
  assign grant1 = i_req1_valid & (~i_req0_valid | ~last_grant);

  assign o_req0_ready = can_accept & grant0;
  assign o_req1_ready = can_accept & grant1;
  assign accept       = o_req0_ready | o_req1_ready;

  assign win_data  = o_req1_ready ? i_req1_data : i_req0_data;
  assign win_fault = (win_data[40:36] != 5'd0);

  always_comb begin
    win_dest = DEST_DCACHE;
    if (win_fault) win_dest = win_data[35] ? DEST_RETIRE : DEST_EXP;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      full       <= 1'b0;
      pkt_q      <= '0;
      owner_q    <= 1'b0;
      dest_q     <= DEST_DCACHE;
      last_grant <= 1'b1;
      cnt0_q     <= '0;
      cnt1_q     <= '0;
    end else begin
      if (accept) begin
        full       <= 1'b1;
        pkt_q      <= win_data;
        owner_q    <= o_req1_ready;
        dest_q     <= win_dest;
        last_grant <= o_req1_ready;
        if (win_fault && o_req0_ready && cnt0_q != '1) cnt0_q <= cnt0_q + CNT_W'(1);
        if (win_fault && o_req1_ready && cnt1_q != '1) cnt1_q <= cnt1_q + CNT_W'(1);
      end else if (drain) begin
        full <= 1'b0;
      end
    end
  end

  assign o_dcache_valid = full & ~rst & (dest_q == DEST_DCACHE);
  assign o_retire_valid = full & ~rst & (dest_q == DEST_RETIRE);
  assign o_exp_valid    = full & ~rst & (dest_q == DEST_EXP);

  assign o_dcache_data = {pkt_q[50:47], pkt_q[33:0]};
  assign o_retire_data = {pkt_q[46:41], pkt_q[40:36]};
  assign o_exp_data    = pkt_q[40:36];
  assign o_owner       = owner_q;
  assign o_fault_cnt0  = cnt0_q;
  assign o_fault_cnt1  = cnt1_q;

endmodule

// File: tb/tb_mmu_pmpout_arb.sv
// Self-checking bench for mmu_pmpout_arb: field-level behavioural model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_mmu_pmpout_arb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_req0_valid = 1'b0;
  logic [50:0] i_req0_data  = '0;
  logic        o_req0_ready;
  logic        i_req1_valid = 1'b0;
  logic [50:0] i_req1_data  = '0;
  logic        o_req1_ready;
  logic        o_dcache_valid;
  logic        i_dcache_ready = 1'b1;
  logic [37:0] o_dcache_data;
  logic        o_retire_valid;
  logic        i_retire_ready = 1'b1;
  logic [10:0] o_retire_data;
  logic        o_exp_valid;
  logic        i_exp_ready = 1'b1;
  logic [4:0]  o_exp_data;
  logic        o_owner;
  logic [7:0]  o_fault_cnt0;
  logic [7:0]  o_fault_cnt1;

  mmu_pmpout_arb #(.DATA_W(51), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .i_req0_valid(i_req0_valid), .i_req0_data(i_req0_data), .o_req0_ready(o_req0_ready),
    .i_req1_valid(i_req1_valid), .i_req1_data(i_req1_data), .o_req1_ready(o_req1_ready),
    .o_dcache_valid(o_dcache_valid), .i_dcache_ready(i_dcache_ready), .o_dcache_data(o_dcache_data),
    .o_retire_valid(o_retire_valid), .i_retire_ready(i_retire_ready), .o_retire_data(o_retire_data),
    .o_exp_valid(o_exp_valid), .i_exp_ready(i_exp_ready), .o_exp_data(o_exp_data),
    .o_owner(o_owner), .o_fault_cnt0(o_fault_cnt0), .o_fault_cnt1(o_fault_cnt1)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [50:0] mk(input logic [3:0] way, input logic [5:0] idx,
                                     input logic [4:0] mc, input logic [1:0] it,
                                     input logic [33:0] pa);
    return {way, idx, mc, it, pa};
  endfunction

  // Model: the held entry as plain fields, counters as ints clamped at 255.
  bit          m_full  = 0;
  logic [50:0] m_pkt   = '0;
  bit          m_owner = 0;
  bit          m_lg    = 1;
  int          m_cnt0  = 0;
  int          m_cnt1  = 0;

  // 0 = dcache, 1 = retire, 2 = exception unit
  function automatic int m_target(input logic [50:0] p);
    if (p[40:36] == 5'd0) return 0;
    return p[35] ? 1 : 2;
  endfunction

  function automatic bit m_target_ready();
    case (m_target(m_pkt))
      0:       return i_dcache_ready;
      1:       return i_retire_ready;
      default: return i_exp_ready;
    endcase
  endfunction

  // Which requester gets accepted this cycle, as {req1, req0}.
  function automatic logic [1:0] m_grants();
    bit room;
    room = !m_full || m_target_ready();
    if (rst || !room) return 2'b00;
    if (i_req0_valid && i_req1_valid) return m_lg ? 2'b01 : 2'b10;
    return {i_req1_valid, i_req0_valid};
  endfunction

  always @(posedge clk) begin
    logic [1:0]  g;
    logic [50:0] p;
    g = m_grants();
    if (rst) begin
      m_full = 0; m_pkt = '0; m_owner = 0; m_lg = 1; m_cnt0 = 0; m_cnt1 = 0;
    end else if (g != 2'b00) begin
      p = g[1] ? i_req1_data : i_req0_data;
      m_full = 1; m_pkt = p; m_owner = g[1]; m_lg = g[1];
      if (p[40:36] != 5'd0) begin
        if (g[0] && m_cnt0 < 255) m_cnt0++;
        if (g[1] && m_cnt1 < 255) m_cnt1++;
      end
    end else if (m_full && m_target_ready()) begin
      m_full = 0;
    end
  end

  always @(negedge clk) begin
    logic [1:0] g;
    bit         show;
    int         t;
    g    = m_grants();
    show = m_full && !rst;
    t    = m_target(m_pkt);
    check("req0_ready", o_req0_ready, g[0]);
    check("req1_ready", o_req1_ready, g[1]);
    check("dcache_valid", o_dcache_valid, show && t == 0);
    check("retire_valid", o_retire_valid, show && t == 1);
    check("exp_valid", o_exp_valid, show && t == 2);
    check("dcache_data", o_dcache_data, {m_pkt[50:47], m_pkt[33:0]});
    check("retire_data", o_retire_data, {m_pkt[46:41], m_pkt[40:36]});
    check("exp_data", o_exp_data, m_pkt[40:36]);
    check("owner", o_owner, m_owner);
    check("fault_cnt0", o_fault_cnt0, 64'(m_cnt0));
    check("fault_cnt1", o_fault_cnt1, 64'(m_cnt1));
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic [50:0] pkt_a;
  logic [50:0] pkt_b;

  initial begin
    cyc(); cyc();
    rst = 1'b0;

    // Single no-fault packet to dcache.
    i_req0_valid = 1'b1;
    i_req0_data  = mk(4'h5, 6'd0, 5'd0, 2'b00, 34'h1_2345_6789);
    @(negedge clk);
    check("t1_ready0", o_req0_ready, 1'b1);
    cyc();
    i_req0_valid = 1'b0;
    @(negedge clk);
    check("t1_dcache_valid", o_dcache_valid, 1'b1);
    check("t1_dcache_data", o_dcache_data, 38'h15_2345_6789);
    check("t1_owner", o_owner, 1'b0);
    check("t1_cnt0", o_fault_cnt0, 8'd0);
    cyc();

    // Fault routing from requester 1.
    i_req1_valid = 1'b1;
    i_req1_data  = mk(4'h0, 6'd9, 5'd5, 2'b10, 34'h0);
    @(negedge clk);
    check("t2_ready1_a", o_req1_ready, 1'b1);
    cyc();
    i_req1_data = mk(4'h3, 6'd1, 5'd13, 2'b01, 34'h0_0000_0abc);
    @(negedge clk);
    check("t2_retire_valid", o_retire_valid, 1'b1);
    check("t2_retire_data", o_retire_data, 11'h125);
    check("t2_ready1_b", o_req1_ready, 1'b1);
    cyc();
    i_req1_valid = 1'b0;
    @(negedge clk);
    check("t2_exp_valid", o_exp_valid, 1'b1);
    check("t2_exp_data", o_exp_data, 5'd13);
    check("t2_cnt1", o_fault_cnt1, 8'd2);
    cyc();

    // Round-robin after a fresh reset, both always valid.
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    i_req0_valid = 1'b1;
    i_req0_data  = mk(4'h1, 6'd2, 5'd0, 2'b00, 34'h0_0000_1000);
    i_req1_valid = 1'b1;
    i_req1_data  = mk(4'h2, 6'd3, 5'd0, 2'b00, 34'h0_0000_2000);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("t3_grant0", o_req0_ready, (i % 2) == 0);
      check("t3_grant1", o_req1_ready, (i % 2) == 1);
      cyc();
    end
    i_req0_valid = 1'b0;
    i_req1_valid = 1'b0;
    cyc();

    // Back-pressure on dcache while retire is ready.
    i_dcache_ready = 1'b0;
    pkt_a = mk(4'h7, 6'd4, 5'd0, 2'b11, 34'h2_0000_0001);
    pkt_b = mk(4'h8, 6'd5, 5'd0, 2'b00, 34'h3_0000_0002);
    i_req0_valid = 1'b1;
    i_req0_data  = pkt_a;
    cyc();
    i_req0_data  = pkt_b;
    i_req1_valid = 1'b1;
    i_req1_data  = mk(4'h9, 6'd6, 5'd0, 2'b00, 34'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t4_stall_valid", o_dcache_valid, 1'b1);
      check("t4_stall_data", o_dcache_data, {4'h7, 34'h2_0000_0001});
      check("t4_stall_rdy", {o_req1_ready, o_req0_ready}, 2'b00);
      cyc();
    end
    i_dcache_ready = 1'b1;
    @(negedge clk);
    check("t4_release_rdy1", o_req1_ready, 1'b1);
    cyc();
    i_req1_valid = 1'b0;
    @(negedge clk);
    check("t4_after_owner", o_owner, 1'b1);
    cyc();
    check("t4_next_rdy0", o_req0_ready, 1'b1);
    cyc();
    i_req0_valid = 1'b0;
    @(negedge clk);
    check("t4_next_data", o_dcache_data, {4'h8, 34'h3_0000_0002});
    cyc();

    // Saturation of requester 0 fault counter.
    i_req0_valid = 1'b1;
    i_req0_data  = mk(4'h0, 6'd0, 5'd1, 2'b00, 34'h0);
    for (int i = 0; i < 260; i++) cyc();
    i_req0_valid = 1'b0;
    @(negedge clk);
    check("t5_cnt0_sat", o_fault_cnt0, 8'd255);
    cyc();

    // Reset while stalled on the exception unit.
    i_exp_ready  = 1'b0;
    i_req1_valid = 1'b1;
    i_req1_data  = mk(4'h0, 6'd0, 5'd3, 2'b00, 34'h0);
    cyc();
    i_req1_valid = 1'b0;
    cyc(); cyc();
    @(negedge clk);
    check("t6_stalled", o_exp_valid, 1'b1);
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    @(negedge clk);
    check("t6_valids", {o_dcache_valid, o_retire_valid, o_exp_valid}, 3'b000);
    check("t6_cnt0", o_fault_cnt0, 8'd0);
    check("t6_cnt1", o_fault_cnt1, 8'd0);
    cyc();
    i_exp_ready  = 1'b1;
    i_req0_valid = 1'b1;
    i_req1_valid = 1'b1;
    i_req0_data  = mk(4'h4, 6'd0, 5'd0, 2'b00, 34'h5);
    i_req1_data  = mk(4'h6, 6'd0, 5'd0, 2'b00, 34'h6);
    @(negedge clk);
    check("t6_tie_rdy", {o_req1_ready, o_req0_ready}, 2'b01);
    cyc();
    i_req0_valid = 1'b0;
    i_req1_valid = 1'b0;
    cyc(); cyc();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
